uart_tx: RTL

UART transmitter that serialises bytes onto a single line as 8-bit frames, LSB first, with optional parity and one or two stop bits. It sits beside the UART receiver on the same 50 MHz fabric clock and shares its bit-timing parameter, so a loop-back of the two recovers the original byte. A one-entry holding register with a valid/ready handshake lets the upstream logic queue the next byte while the current frame is on the wire, so frames can go out back-to-back.

---
 rtl/uart_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8-bit LSB-first frames with optional parity and 1/2 stop bits,
// fed through a one-entry holding register so frames can go out back-to-back.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_50M,
  input  logic       i_rst_n,
  input  logic [7:0] i_data_byte,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic       o_Tx,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic        PAR_ODD  = (PARITY_ODD != 0);
  localparam logic        PAR_EN   = (PARITY_EN != 0);
  localparam logic        ONE_STOP = (STOP_BITS == 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_q, tx_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  logic accept;
  logic take;
  logic bit_end;
  logic last_stop;

  assign accept    = i_data_valid && !hold_full_q;
  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_stop = ONE_STOP || stop_idx_q;

  // Line outputs are registered from the current state, so o_Tx lags the FSM
  // by one cycle; o_tx_done is aligned to the last stop cycle on the line.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + 16'd1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    take       = 1'b0;
    tx_d       = 1'b1;
    done_d     = 1'b0;
    active_d   = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hold_full_q) begin
          shift_d = hold_q;
          take    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[bit_idx_q];
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d    = PAR_EN ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        tx_d = (^shift_q) ^ PAR_ODD;
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (last_stop) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              shift_d = hold_q;
              take    = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    hold_d      = accept ? i_data_byte : hold_q;
    hold_full_d = accept ? 1'b1 : (take ? 1'b0 : hold_full_q);
  end

  always_ff @(posedge clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign o_data_ready = !hold_full_q;
  assign o_Tx         = tx_q;
  assign o_tx_active  = active_q;
  assign o_tx_done    = done_q;

endmodule
